dco_nco_bank: RTL and testbench
===============================

# dco_nco_bank

Parametrised multi-channel digitally controlled oscillator, the successor to the single 8-bit DCO. Each channel is a phase accumulator whose increment is a frequency code, so f_out = f_clk × code / 2^ACC_W. Codes are double-buffered and applied only at a phase wrap, so output changes are glitch-free. A global mode selects square, single-cycle pulse, or divided-toggle output, and a sync input phase-aligns all channels. Sits between the pin-level code interface and the output pads.

## Interface
Parameters:
- CODE_W, 8, frequency code width; must be ≤ ACC_W
- ACC_W, 12, phase accumulator width
- CHANNELS, 2, number of independent oscillators (≥1)

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- ena  in  1  run enable; low freezes all accumulators and outputs
- code_in  in  CODE_W  frequency code to write
- code_sel  in  max(1,$clog2(CHANNELS))  target channel of the write
- code_wr  in  1  write strobe, one cycle
- mode  in  2  0 = square, 1 = pulse, 2 = toggle, 3 = reserved (behaves as 0)
- sync  in  1  phase reset of all channels
- dco_out  out  CHANNELS  oscillator outputs, registered
- wrap  out  CHANNELS  one-cycle pulse per channel wrap, registered
- pending  out  CHANNELS  shadow code not yet applied

## Operation
- Per channel: shadow code (sh), active code (act), accumulator acc[ACC_W], toggle flop tg, pending flag.
- Write: code_wr with a valid code_sel loads sh and sets pending. A later write overwrites sh, so last write wins. A code_sel ≥ CHANNELS is ignored. Writes are accepted regardless of ena.
- Advance (ena=1, act≠0): {carry, acc} ← acc + act (act zero-extended to ACC_W). carry=1 defines a wrap.
- Apply: on a wrap, or on any enabled cycle with act=0 (idle channel), if pending then act ← sh and pending clears. The value applied is the one present in sh at the start of the cycle. A write in the same cycle lands in sh and stays pending.
- act=0: acc holds, no wrap, dco_out holds.
- Outputs per mode:
  - square: dco_out = acc MSB.
  - pulse: dco_out = wrap.
  - toggle: tg flips on each wrap; dco_out = tg (50 % duty, f/2).
- sync=1 (and ena=1): acc ← 0 and tg ← 0 for all channels; pending codes are applied; no wrap pulse is produced. sync has priority over a simultaneous wrap.
- ena=0: acc, tg, and act hold; wrap=0; dco_out holds its last value; sync is ignored.
- Mode change takes effect on the next registered output; acc is not disturbed.

## Timing
- Reset values: acc=0, act=0, sh=0, tg=0, pending=0, dco_out=0, wrap=0.
- Reset is asynchronous assert and synchronous-safe deassert; state is cleared immediately, mid-operation included.
- code_wr at edge t: pending=1 after t. For an idle channel, act is updated at t+1 and acc starts advancing at t+2.
- Wrap latency: carry is computed in cycle n; wrap and dco_out reflect it after edge n+1.
- Wrap period = 2^ACC_W / act cycles, exact when act divides 2^ACC_W; otherwise the period jitters by one cycle, with exact long-term average.
- Max code (2^CODE_W − 1 with CODE_W = ACC_W) wraps on almost every cycle; the square-mode output is then legal but aliased.

## Structure
- Package dco_pkg: mode_e enum (MODE_SQUARE, MODE_PULSE, MODE_TOGGLE, MODE_RSVD), width helper functions.
- Sub-module dco_channel: one accumulator with its shadow/active/pending logic, tg, and output mux. The top generates CHANNELS instances and decodes code_wr/code_sel.

## Test plan
- Reset, then ACC_W=8, ch0 write 64, square, ena=1 -> pending clears 1 cycle later; dco_out[0] period 4 cycles (2 high/2 low); wrap[0] every 4 cycles.
- Ch0 running at 64, write 32 mid-period -> pending=1 until the next wrap; the following period is exactly 8 cycles with no short or long half-cycle.
- Two writes (16 then 128) before a wrap -> only 128 is applied; a write coincident with the wrap cycle stays pending one more period.
- Toggle mode, code 64, ACC_W=8 -> dco_out period 8 cycles; pulse mode -> a single-cycle high every 4 cycles.
- Channels at 64 and 32, assert sync for 1 cycle -> both acc=0, both dco_out low next cycle, no wrap pulse; a sync coincident with a wrap suppresses that pulse.
- ena=0 for 10 cycles mid-run -> outputs frozen and wrap=0; resumes at the same phase. Assert rst mid-period -> all outputs 0 immediately; code_sel=CHANNELS write is ignored.

Source files
------------

// File: rtl/dco_nco_bank_pkg.sv
// Shared types and width helpers for the multi-channel phase-accumulator DCO bank.
package dco_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Channel-select width; a single channel still needs a one-bit select port.
    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dco_nco_bank_if.sv
// Code-write / control / output bundle between the code interface and the DCO bank.
interface dco_nco_bank_if import dco_pkg::*; #(
    parameter int CODE_W   = 8,
    parameter int CHANNELS = 2
) ();

    localparam int SEL_W = sel_w(CHANNELS);

    logic                ena;
    logic [CODE_W-1:0]   code_in;
    logic [SEL_W-1:0]    code_sel;
    logic                code_wr;
    mode_e               mode;
    logic                sync;
    logic [CHANNELS-1:0] dco_out;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] pending;

    modport master (
        output ena, code_in, code_sel, code_wr, mode, sync,
        input  dco_out, wrap, pending
    );

    modport slave (
        input  ena, code_in, code_sel, code_wr, mode, sync,
        output dco_out, wrap, pending
    );

endinterface

// File: rtl/dco_nco_bank_channel.sv
// One oscillator: phase accumulator with double-buffered frequency code,
// toggle flop and registered output mux.
module dco_channel import dco_pkg::*; #(
    parameter int CODE_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              sync,
    input  mode_e             mode,
    input  logic              wr,
    input  logic [CODE_W-1:0] code,
    output logic              dco_out,
    output logic              wrap,
    output logic              pending
);

    logic [CODE_W-1:0] sh;
    logic [CODE_W-1:0] act;
    logic [ACC_W-1:0]  acc;
    logic              tg;

    logic [ACC_W:0]    sum;
    logic              running;
    logic              carry;
    logic              apply;
    logic              wrap_c;
    logic [ACC_W-1:0]  acc_next;
    logic              tg_next;
    logic              dco_next;

    // An idle channel (act=0) picks up a pending code on any enabled cycle;
    // a running one only at a wrap or sync, which keeps retunes glitch-free.
    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_W + 1 - CODE_W){1'b0}}, act};
        running  = (act != '0);
        carry    = running && sum[ACC_W];
        apply    = sync || !running || carry;
        wrap_c   = carry && !sync;
        acc_next = sync ? '0 : (running ? sum[ACC_W-1:0] : acc);
        tg_next  = sync ? 1'b0 : (tg ^ wrap_c);
        case (mode)
            MODE_PULSE:  dco_next = wrap_c;
            MODE_TOGGLE: dco_next = tg_next;
            default:     dco_next = acc_next[ACC_W-1];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            act     <= '0;
            acc     <= '0;
            tg      <= 1'b0;
            pending <= 1'b0;
            wrap    <= 1'b0;
            dco_out <= 1'b0;
        end else begin
            if (wr) begin
                sh <= code;
            end
            // A write in the same cycle as an apply keeps the new code pending.
            if (wr) begin
                pending <= 1'b1;
            end else if (ena && apply) begin
                pending <= 1'b0;
            end
            if (ena && apply && pending) begin
                act <= sh;
            end
            if (ena) begin
                acc <= acc_next;
                tg  <= tg_next;
            end
            wrap <= ena && wrap_c;
            if (ena && (running || sync)) begin
                dco_out <= dco_next;
            end
        end
    end

endmodule

// File: rtl/dco_nco_bank.sv
// Multi-channel DCO bank: decodes code writes to channels and gathers their outputs.
module dco_nco_bank import dco_pkg::*; #(
    parameter int CODE_W   = 8,
    parameter int ACC_W    = 12,
    parameter int CHANNELS = 2
) (
    input  logic           clk,
    input  logic           rst,
    dco_nco_bank_if.slave  bus
);

    localparam int SEL_W = sel_w(CHANNELS);

    logic [CHANNELS-1:0] wr_vec;
    logic [CHANNELS-1:0] dco_v;
    logic [CHANNELS-1:0] wrap_v;
    logic [CHANNELS-1:0] pend_v;

    // Selects at or beyond CHANNELS match no channel, so such writes vanish.
    always_comb begin
        wr_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_vec[i] = bus.code_wr && (bus.code_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        dco_channel #(
            .CODE_W (CODE_W),
            .ACC_W  (ACC_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ena     (bus.ena),
            .sync    (bus.sync),
            .mode    (bus.mode),
            .wr      (wr_vec[g]),
            .code    (bus.code_in),
            .dco_out (dco_v[g]),
            .wrap    (wrap_v[g]),
            .pending (pend_v[g])
        );
    end

    assign bus.dco_out = dco_v;
    assign bus.wrap    = wrap_v;
    assign bus.pending = pend_v;

endmodule

// File: tb/tb_dco_nco_bank.sv
// Scoreboard bench for dco_nco_bank with an 8-bit accumulator and three channels.
module tb_dco_nco_bank;
    import dco_pkg::*;

    localparam int CW      = 8;
    localparam int AW      = 8;
    localparam int NCH     = 3;
    localparam int ACC_MOD = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dco_nco_bank_if #(.CODE_W(CW), .CHANNELS(NCH)) bus ();

    dco_nco_bank #(.CODE_W(CW), .ACC_W(AW), .CHANNELS(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [3*NCH-1:0] exp_q[$];
    logic [3*NCH-1:0] exp_v;
    logic [3*NCH-1:0] got_v;

    int m_sh  [NCH];
    int m_act [NCH];
    int m_acc [NCH];
    bit m_tg  [NCH];
    bit m_pend[NCH];
    bit m_dco [NCH];
    bit m_wrap[NCH];

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_sh[ch] = 0; m_act[ch] = 0; m_acc[ch] = 0;
            m_tg[ch] = 0; m_pend[ch] = 0; m_dco[ch] = 0; m_wrap[ch] = 0;
        end
        exp_q.delete();
    endtask

    // Behavioural reference: predicts the state after the coming clock edge.
    task automatic model_step();
        for (int ch = 0; ch < NCH; ch++) begin
            bit hit, carry, apply, ntg, w;
            int nacc;
            hit   = bus.code_wr && (int'(bus.code_sel) == ch);
            w     = 0;
            apply = 0;
            nacc  = m_acc[ch];
            ntg   = m_tg[ch];
            if (bus.ena) begin
                carry = (m_act[ch] != 0) && (m_acc[ch] + m_act[ch] >= ACC_MOD);
                if (bus.sync) begin
                    nacc = 0; ntg = 0; apply = 1;
                end else if (m_act[ch] != 0) begin
                    nacc  = (m_acc[ch] + m_act[ch]) % ACC_MOD;
                    w     = carry;
                    ntg   = m_tg[ch] ^ carry;
                    apply = carry;
                end else begin
                    apply = 1;
                end
                if (m_act[ch] != 0 || bus.sync) begin
                    case (bus.mode)
                        MODE_PULSE:  m_dco[ch] = w;
                        MODE_TOGGLE: m_dco[ch] = ntg;
                        default:     m_dco[ch] = (nacc >= ACC_MOD / 2);
                    endcase
                end
                if (apply && m_pend[ch]) begin
                    m_act[ch]  = m_sh[ch];
                    m_pend[ch] = 0;
                end
            end
            if (hit) begin
                m_sh[ch]   = int'(bus.code_in);
                m_pend[ch] = 1;
            end
            m_acc[ch]  = nacc;
            m_tg[ch]   = ntg;
            m_wrap[ch] = w;
        end
    endtask

    task automatic tick();
        logic [3*NCH-1:0] v;
        model_step();
        for (int ch = 0; ch < NCH; ch++) begin
            v[ch]         = m_dco[ch];
            v[NCH + ch]   = m_wrap[ch];
            v[2*NCH + ch] = m_pend[ch];
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.code_wr = 1'b0;
        bus.sync    = 1'b0;
    endtask

    task automatic write_code(input int sel, input int code);
        bus.code_sel = sel[1:0];
        bus.code_in  = code[CW-1:0];
        bus.code_wr  = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_run++;
        if ({bus.pending, bus.wrap, bus.dco_out} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state got %b exp 0", {bus.pending, bus.wrap, bus.dco_out});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_square();
        int wraps, highs;
        bus.mode = MODE_SQUARE;
        bus.ena  = 1'b1;
        write_code(0, 64);
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL square_wr got %b exp %b", got_v, exp_v); end
        n_run++;
        if (bus.pending[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL square_pend_set got %b exp 1", bus.pending[0]); end
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL square_apply got %b exp %b", got_v, exp_v); end
        n_run++;
        if (bus.pending[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL square_pend_clr got %b exp 0", bus.pending[0]); end
        wraps = 0; highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL square_run cyc %0d got %b exp %b", i, got_v, exp_v); end
            wraps += int'(bus.wrap[0]);
            highs += int'(bus.dco_out[0]);
        end
        n_run++;
        if (wraps != 4 || highs != 8) begin
            n_fail++;
            $display("[TB] FAIL square_period wraps %0d highs %0d exp 4 and 8", wraps, highs);
        end
    endtask

    task automatic test_retune();
        int wraps;
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL retune_pre got %b exp %b", got_v, exp_v); end
        write_code(0, 32);
        wraps = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL retune_run cyc %0d got %b exp %b", i, got_v, exp_v); end
            if (i >= 8) wraps += int'(bus.wrap[0]);
        end
        n_run++;
        if (wraps != 2) begin n_fail++; $display("[TB] FAIL retune_period wraps %0d exp 2", wraps); end
    endtask

    task automatic test_last_write();
        int  budget;
        bit  seen;
        seen = 0; budget = 0;
        while (!seen && budget < 20) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL lastwr_find got %b exp %b", got_v, exp_v); end
            seen = bus.wrap[0];
            budget++;
        end
        n_run++;
        if (!seen) begin n_fail++; $display("[TB] FAIL lastwr_timeout got no wrap exp wrap within 20"); end
        for (int i = 0; i < 12; i++) begin
            if (i == 0) write_code(0, 16);
            if (i == 1) write_code(0, 128);
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL lastwr_run cyc %0d got %b exp %b", i, got_v, exp_v); end
        end
        seen = 0; budget = 0;
        while (!seen && budget < 8) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL coinc_find got %b exp %b", got_v, exp_v); end
            seen = bus.wrap[0];
            budget++;
        end
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL coinc_mid got %b exp %b", got_v, exp_v); end
        write_code(0, 64);
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL coinc_wr got %b exp %b", got_v, exp_v); end
        n_run++;
        if (bus.wrap[0] !== 1'b1 || bus.pending[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL coinc_pending got wrap %b pend %b exp 1 1", bus.wrap[0], bus.pending[0]);
        end
    endtask

    task automatic test_modes();
        int  highs, edges;
        bit  prev;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL mode_warm cyc %0d got %b exp %b", i, got_v, exp_v); end
        end
        bus.mode = MODE_TOGGLE;
        highs = 0; edges = 0; prev = bus.dco_out[0];
        for (int i = 0; i < 24; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL toggle_run cyc %0d got %b exp %b", i, got_v, exp_v); end
            if (i >= 8) begin
                highs += int'(bus.dco_out[0]);
                edges += int'(bus.dco_out[0] != prev);
            end
            prev = bus.dco_out[0];
        end
        n_run++;
        if (highs != 8 || edges != 4) begin
            n_fail++;
            $display("[TB] FAIL toggle_period highs %0d edges %0d exp 8 and 4", highs, edges);
        end
        bus.mode = MODE_PULSE;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL pulse_run cyc %0d got %b exp %b", i, got_v, exp_v); end
            if (i >= 4) highs += int'(bus.dco_out[0]);
        end
        n_run++;
        if (highs != 4) begin n_fail++; $display("[TB] FAIL pulse_count got %0d exp 4", highs); end
    endtask

    task automatic test_sync();
        bus.mode = MODE_SQUARE;
        write_code(1, 32);
        for (int i = 0; i < 11; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL sync_warm cyc %0d got %b exp %b", i, got_v, exp_v); end
        end
        bus.sync = 1'b1;
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL sync_pulse got %b exp %b", got_v, exp_v); end
        n_run++;
        if (bus.dco_out[1:0] !== 2'b00 || bus.wrap !== '0) begin
            n_fail++;
            $display("[TB] FAIL sync_zero got dco %b wrap %b exp 00 000", bus.dco_out[1:0], bus.wrap);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.sync = 1'b1;
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL sync_coinc cyc %0d got %b exp %b", i, got_v, exp_v); end
        end
        n_run++;
        if (bus.wrap[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL sync_suppress got %b exp 0", bus.wrap[0]); end
    endtask

    task automatic test_freeze();
        logic [NCH-1:0] snap;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL freeze_pre cyc %0d got %b exp %b", i, got_v, exp_v); end
        end
        snap    = bus.dco_out;
        bus.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) bus.sync = 1'b1;
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v || bus.dco_out !== snap || bus.wrap !== '0) begin
                n_fail++;
                $display("[TB] FAIL freeze_hold cyc %0d got %b exp %b", i, got_v, exp_v);
            end
        end
        bus.ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL freeze_resume cyc %0d got %b exp %b", i, got_v, exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        write_code(2, 64);
        tick();
        exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
        n_run++;
        if (got_v !== exp_v) begin n_fail++; $display("[TB] FAIL rstmid_pre got %b exp %b", got_v, exp_v); end
        #3;
        rst = 1'b1;
        #1;
        n_run++;
        if ({bus.pending, bus.wrap, bus.dco_out} !== '0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_async got %b exp 0", {bus.pending, bus.wrap, bus.dco_out});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) write_code(NCH, 50);
            tick();
            exp_v = exp_q.pop_front(); got_v = {bus.pending, bus.wrap, bus.dco_out};
            n_run++;
            if (got_v !== exp_v || bus.pending !== '0) begin
                n_fail++;
                $display("[TB] FAIL badsel cyc %0d got %b exp %b", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ena      = 1'b0;
        bus.code_in  = '0;
        bus.code_sel = '0;
        bus.code_wr  = 1'b0;
        bus.mode     = MODE_SQUARE;
        bus.sync     = 1'b0;
        test_reset();
        test_square();
        test_retune();
        test_last_write();
        test_modes();
        test_sync();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
